// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/commit controller in front of the basic_arch ALU.
//
// Accepts one RV32 instruction per handshake and walks it through
// IDLE -> DECODE -> EXEC -> COMMIT -> IDLE. The accept edge is cycle 0 and the
// commit strobes are high in cycle 3.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   instr_valid/instr_ready fetch handshake; instr and pc are latched on accept
//   rs1_addr, rs2_addr      register-file read addresses (ALU a / rs2 operand)
//   alu_op, alu_b_sel, imm  ALU control, held from DECODE through COMMIT
//   alu_result, alu_branch  ALU outputs, sampled at the end of EXEC
//   rf_we, rf_rd, rf_wdata  register-file write (rf_we is a 1-cycle strobe)
//   pc_we, pc_next          PC update (pc_we is a 1-cycle strobe)
//   illegal                 1-cycle pulse in COMMIT for an unsupported instruction
//   busy                    high whenever the FSM is not idle
module alu_issue_ctrl #(
  parameter bit ALLOW_MUL   = 1'b1,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [3:0]  alu_op,
  output logic        alu_b_sel,
  output logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        alu_branch,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        pc_we,
  output logic [31:0] pc_next,
  output logic        illegal,
  output logic        busy
);

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StCommit} state_e;

  state_e state_q, state_d;

  // Instruction and PC latched on accept.
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Decoded class, registered in DECODE.
  logic is_branch_q;
  logic is_illegal_q;
  logic br_inv_q;   // branch taken when the ALU compare is false (BNE/BGEU)

  // Instruction fields.
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

  // Immediate formats.
  logic [31:0] imm_i;
  logic [31:0] imm_sh;
  logic [31:0] imm_b;

  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_sh = {27'd0, instr_q[24:20]};
  assign imm_b  = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};

  // Combinational decode of the latched instruction.
  logic [3:0]  dec_op;
  logic        dec_bsel;
  logic [31:0] dec_imm;
  logic        dec_branch;
  logic        dec_inv;
  logic        dec_illegal;

  always_comb begin
    dec_op      = 4'b0000;
    dec_bsel    = 1'b0;
    dec_imm     = 32'd0;
    dec_branch  = 1'b0;
    dec_inv     = 1'b0;
    dec_illegal = 1'b0;

    case (opcode)
      OpcReg: begin
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec_op = 4'b0000;  // ADD
          {7'h20, 3'b000}: dec_op = 4'b0001;  // SUB
          {7'h00, 3'b001}: dec_op = 4'b0010;  // SLL
          {7'h00, 3'b101}: dec_op = 4'b0100;  // SRL
          {7'h00, 3'b111}: dec_op = 4'b0011;  // AND
          {7'h00, 3'b110}: dec_op = 4'b0110;  // OR
          {7'h01, 3'b000}: begin              // MUL
            if (ALLOW_MUL) begin
              dec_op = 4'b1000;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OpcImm: begin
        dec_bsel = 1'b1;
        dec_imm  = imm_i;
        case (funct3)
          3'b000: dec_op = 4'b0000;  // ADDI
          3'b111: dec_op = 4'b0011;  // ANDI
          3'b110: dec_op = 4'b0110;  // ORI
          3'b001, 3'b101: begin      // SLLI / SRLI: shamt only, upper bits must be zero
            dec_imm = imm_sh;
            if (funct7 != 7'd0) begin
              dec_illegal = 1'b1;
            end else begin
              dec_op = (funct3 == 3'b001) ? 4'b0010 : 4'b0100;
            end
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OpcBranch: begin
        dec_branch = 1'b1;
        dec_imm    = imm_b;
        case (funct3)
          3'b000: dec_op = 4'b1100;                    // BEQ
          3'b001: begin dec_op = 4'b1100; dec_inv = 1'b1; end  // BNE
          3'b110: dec_op = 4'b0101;                    // BLTU
          3'b111: begin dec_op = 4'b0101; dec_inv = 1'b1; end  // BGEU
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase

    // Illegal instructions still flow through the pipe but drive a benign ALU setup.
    if (dec_illegal) begin
      dec_op     = 4'b0000;
      dec_bsel   = 1'b0;
      dec_imm    = 32'd0;
      dec_branch = 1'b0;
      dec_inv    = 1'b0;
    end
  end

  // Next-state logic: the FSM never stalls once an instruction is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (instr_valid) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);

  // Commit values computed from the live ALU outputs during EXEC.
  logic        br_taken;
  logic [31:0] pc_seq;
  logic [31:0] pc_target;

  assign br_taken  = alu_branch ^ br_inv_q;
  assign pc_seq    = pc_q + 32'd4;
  assign pc_target = pc_q + imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      instr_q      <= 32'd0;
      pc_q         <= 32'd0;
      is_branch_q  <= 1'b0;
      is_illegal_q <= 1'b0;
      br_inv_q     <= 1'b0;
      rs1_addr     <= 5'd0;
      rs2_addr     <= 5'd0;
      alu_op       <= 4'b0000;
      alu_b_sel    <= 1'b0;
      imm          <= 32'd0;
      rf_we        <= 1'b0;
      rf_rd        <= 5'd0;
      rf_wdata     <= 32'd0;
      pc_we        <= 1'b0;
      pc_next      <= 32'd0;
      illegal      <= 1'b0;
    end else begin
      state_q <= state_d;
      // Strobes are single-cycle: only the EXEC->COMMIT edge raises them.
      rf_we   <= 1'b0;
      pc_we   <= 1'b0;
      illegal <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            instr_q <= instr;
            pc_q    <= pc;
          end
        end
        StDecode: begin
          rs1_addr     <= rs1;
          rs2_addr     <= rs2;
          alu_op       <= dec_op;
          alu_b_sel    <= dec_bsel;
          imm          <= dec_imm;
          is_branch_q  <= dec_branch;
          is_illegal_q <= dec_illegal;
          br_inv_q     <= dec_inv;
        end
        StExec: begin
          pc_we <= 1'b1;
          if (is_illegal_q) begin
            illegal <= 1'b1;
            pc_next <= pc_seq;
          end else if (is_branch_q) begin
            // The ALU leaves result untouched on compares, so only the flag matters.
            pc_next <= br_taken ? pc_target : pc_seq;
          end else begin
            pc_next  <= pc_seq;
            rf_rd    <= rd;
            rf_wdata <= alu_result;
            rf_we    <= !(SUPPRESS_X0 && (rd == 5'd0));
          end
        end
        StCommit: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
